// File: rtl/fpu_rr_arbiter_if.sv
// Bundles the requester ports, response ports and fpu handshake of the arbiter.
// slave: arbiter view. master: the surrounding requesters + fpu (or a testbench).
// Pure wiring, no state.
interface fpu_rr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_op;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_data;
  logic                  resp_err;
  logic                  fpu_start;
  logic                  fpu_op;
  logic [31:0]           fpu_a;
  logic [31:0]           fpu_b;
  logic                  fpu_ready;
  logic [31:0]           fpu_c;
  logic                  busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, fpu_ready, fpu_c,
    output req_ready, resp_valid, resp_data, resp_err,
           fpu_start, fpu_op, fpu_a, fpu_b, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, fpu_ready, fpu_c,
    input  req_ready, resp_valid, resp_data, resp_err,
           fpu_start, fpu_op, fpu_a, fpu_b, busy
  );
endinterface

// File: rtl/fpu_rr_arbiter.sv
// Round-robin sharing of one fpu add/sub unit among NUM_REQ requesters.
// Latency: accept edge -> resp_valid 8 cycles later with the nominal fpu; 1 op per 9 cycles.
// Backpressure: requests wait (req_valid held) until granted; responses are a 1-cycle pulse, no backpressure.
module fpu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 31
) (
  input logic             clk,
  input logic             rst,
  fpu_rr_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic               r_op;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [CNT_W-1:0]   r_tmo_cnt;
  logic [31:0]        r_resp_data;
  logic               r_resp_err;

  logic               w_gnt_vld;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_accept;
  logic               w_waiting;
  logic               w_done;
  logic               w_tmo_hit;
  logic [CNT_W-1:0]   w_tmo_nxt;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [NUM_REQ-1:0] w_resp_valid;

  // Round-robin pick: scan downwards so the last hit is the one closest to rr_ptr.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Handshake qualifiers; a new op is only issued while the fpu reports ready.
  always_comb begin
    w_accept  = (r_state == S_IDLE) && !rst && bus.fpu_ready && w_gnt_vld;
    w_waiting = (r_state == S_WAIT_LOW) || (r_state == S_WAIT_DONE);
    w_done    = (r_state == S_WAIT_DONE) && bus.fpu_ready;
    w_tmo_nxt = r_tmo_cnt + CNT_W'(1);
    w_tmo_hit = w_waiting && !w_done && (w_tmo_nxt == CNT_W'(TIMEOUT));
  end

  // Next-state logic; normal completion wins over a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE:     w_state_nxt = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (w_tmo_hit)           w_state_nxt = S_RESP;
        else if (!bus.fpu_ready) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (w_done || w_tmo_hit) w_state_nxt = S_RESP;
      S_RESP:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset drops any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand hold, pointer, owner, timeout counter and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_op        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_tmo_cnt   <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op     <= bus.req_op[w_gnt_idx];
        r_a      <= bus.req_a[int'(w_gnt_idx)*32 +: 32];
        r_b      <= bus.req_b[int'(w_gnt_idx)*32 +: 32];
        r_owner  <= w_gnt_idx;
        r_rr_ptr <= IDX_W'((int'(w_gnt_idx) + 1) % NUM_REQ);
      end
      if (r_state == S_ISSUE) r_tmo_cnt <= '0;
      else if (w_waiting)     r_tmo_cnt <= w_tmo_nxt;
      if (w_done) begin
        r_resp_data <= bus.fpu_c;
        r_resp_err  <= 1'b0;
      end else if (w_tmo_hit) begin
        r_resp_data <= '0;
        r_resp_err  <= 1'b1;
      end
    end
  end

  // One-hot accept and response vectors.
  always_comb begin
    w_req_ready  = '0;
    w_resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_ready[i]  = w_accept && (w_gnt_idx == IDX_W'(i));
      w_resp_valid[i] = (r_state == S_RESP) && (r_owner == IDX_W'(i));
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_err   = (r_state == S_RESP) && r_resp_err;
  assign bus.fpu_start  = (r_state == S_ISSUE);
  assign bus.fpu_op     = r_op;
  assign bus.fpu_a      = r_a;
  assign bus.fpu_b      = r_b;
  assign bus.busy       = (r_state != S_IDLE);

endmodule
